// File: rtl/pebble_pkg.sv
// Shared types and defaults for the Pebble run sequencer.
package pebble_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RST     = 3'd1,
        START   = 3'd2,
        RUN     = 3'd3,
        DONE    = 3'd4,
        TIMEOUT = 3'd5
    } run_state_t;

endpackage

// File: rtl/pebble_sat_counter.sv
// Saturating up-counter; a clear with enable restarts the count and counts the current cycle.
module pebble_sat_counter #(
    parameter int           W   = 16,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= (enable && MAX != '0) ? W'(1) : '0;
        end else if (enable && count != MAX) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pebble_run_ctrl.sv
// Run sequencer for the Pebble core: reset, one-cycle start, count until done or timeout.
module pebble_run_ctrl
    import pebble_pkg::*;
#(
    parameter int RST_CYCLES = 2,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int MAX_CYCLES = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             abort,
    input  logic             core_done,
    output logic             core_reset,
    output logic             core_start,
    output logic             busy,
    output logic             result_valid,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_t    state, next_state;
    logic [RW-1:0] rst_cnt;
    logic          cnt_clear, cnt_en;

    always_comb begin
        next_state = state;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        if (abort && state != IDLE) begin
            next_state = IDLE;
            cnt_clear  = 1'b1;
        end else begin
            case (state)
                IDLE, DONE, TIMEOUT: if (go) next_state = RST;
                RST: if (rst_cnt == RW'(RST_CYCLES - 1)) next_state = START;
                START: begin
                    cnt_clear = 1'b1;
                    if (core_done) begin
                        next_state = DONE;
                    end else begin
                        cnt_en     = 1'b1;
                        next_state = RUN;
                    end
                end
                RUN: begin
                    // done beats the timeout when both land in the same cycle
                    if (core_done)                                next_state = DONE;
                    else if (cycle_count == CNT_W'(MAX_CYCLES))   next_state = TIMEOUT;
                    else                                          cnt_en     = 1'b1;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // outputs are registered from next_state so the core never sees decode glitches
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rst_cnt      <= '0;
            core_reset   <= 1'b1;
            core_start   <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            timed_out    <= 1'b0;
        end else begin
            state        <= next_state;
            rst_cnt      <= (state == RST) ? rst_cnt + RW'(1) : '0;
            core_reset   <= !(next_state == START || next_state == RUN);
            core_start   <= (next_state == START);
            busy         <= (next_state == RST || next_state == START || next_state == RUN);
            result_valid <= (next_state == DONE || next_state == TIMEOUT);
            timed_out    <= (next_state == TIMEOUT);
        end
    end

    pebble_sat_counter #(
        .W   (CNT_W),
        .MAX (CNT_W'(MAX_CYCLES))
    ) u_cycle_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (cycle_count)
    );

endmodule
